// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and parity-mode selectors.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; reset value is
// chosen per use so an idle line does not look active after reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_reg <= RST_VAL;
            sync_reg <= RST_VAL;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first deserialiser with optional parity
// and configurable stop length; status holds until the next completed frame.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            parity_err,
    output logic            busy
);

    localparam int              NW       = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [4:0]      MID      = 5'(MID_SAMPLE);
    localparam logic [4:0]      BIT_LAST = 5'(OVERSAMPLE - 1);
    localparam logic [4:0]      SB_LAST  = 5'(SB_TICK - 1);
    localparam logic [NW-1:0]   N_LAST   = NW'(DBIT - 1);
    localparam logic            ODD_BIT  = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

    rx_state_t       state_reg, state_next;
    logic [4:0]      s_reg, s_next;
    logic [NW-1:0]   n_reg, n_next;
    logic [DBIT-1:0] b_reg, b_next;
    logic            pbit_reg, pbit_next;
    logic [DBIT-1:0] dout_reg, dout_next;
    logic            frame_err_reg, frame_err_next;
    logic            parity_err_reg, parity_err_next;
    logic            done_reg, done_next;
    logic            busy_reg;
    logic            rxs;

    sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rxs)
    );

    always_comb begin
        state_next      = state_reg;
        s_next          = s_reg;
        n_next          = n_reg;
        b_next          = b_reg;
        pbit_next       = pbit_reg;
        dout_next       = dout_reg;
        frame_err_next  = frame_err_reg;
        parity_err_next = parity_err_reg;
        done_next       = 1'b0;
        case (state_reg)
            IDLE: begin
                // start detection is edge-driven, not tick-driven
                if (!rxs) begin
                    state_next = START;
                    s_next     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_reg == MID) begin
                        if (!rxs) begin
                            state_next = DATA;
                            s_next     = '0;
                            n_next     = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_reg == BIT_LAST) begin
                        s_next = '0;
                        b_next = {rxs, b_reg[DBIT-1:1]};
                        if (n_reg == N_LAST)
                            state_next = (PARITY_EN != 0) ? PARITY : STOP;
                        else
                            n_next = n_reg + 1'b1;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (s_reg == BIT_LAST) begin
                        pbit_next  = rxs;
                        s_next     = '0;
                        state_next = STOP;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_reg == SB_LAST) begin
                        dout_next       = b_reg;
                        frame_err_next  = ~rxs;
                        parity_err_next = (PARITY_EN != 0) && (pbit_reg != (^b_reg ^ ODD_BIT));
                        done_next       = 1'b1;
                        state_next      = IDLE;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            s_reg          <= '0;
            n_reg          <= '0;
            b_reg          <= '0;
            pbit_reg       <= 1'b0;
            dout_reg       <= '0;
            frame_err_reg  <= 1'b0;
            parity_err_reg <= 1'b0;
            done_reg       <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            s_reg          <= s_next;
            n_reg          <= n_next;
            b_reg          <= b_next;
            pbit_reg       <= pbit_next;
            dout_reg       <= dout_next;
            frame_err_reg  <= frame_err_next;
            parity_err_reg <= parity_err_next;
            done_reg       <= done_next;
            busy_reg       <= (state_next != IDLE);
        end
    end

    assign dout         = dout_reg;
    assign rx_done_tick = done_reg;
    assign frame_err    = frame_err_reg;
    assign parity_err   = parity_err_reg;
    assign busy         = busy_reg;

endmodule
